// File: rtl/enemy_ammo_controller.sv
// rtl/enemy_ammo_controller.sv - enemy bullet slot tracker with per-pixel sprite lookup
// Fires into the lowest free slot, moves bullets per frame, and resolves the VGA scan pixel.
module enemy_ammo_controller #(
  parameter int NUM_SLOTS = 4,
  parameter int AMMO_W    = 10,
  parameter int AMMO_H    = 20,
  parameter int SPEED     = 4,
  parameter int SCREEN_H  = 480,
  parameter int COOLDOWN  = 30
) (
  input  logic                 vga_clk,
  input  logic                 Reset,
  input  logic                 frame_tick,
  input  logic                 fire,
  input  logic [9:0]           fire_x,
  input  logic [9:0]           fire_y,
  input  logic [NUM_SLOTS-1:0] hit_clear,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic                 fire_accept,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 ammo_on,
  output logic [7:0]           rom_address
);

  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           x_d [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];
  logic [9:0]           y_d [NUM_SLOTS];
  logic [CD_W-1:0]      cd_q, cd_d;
  logic                 fire_accept_q, fire_accept_d;
  logic                 ammo_on_q, ammo_on_d;
  logic [7:0]           rom_address_q, rom_address_d;

  logic [NUM_SLOTS-1:0] free_slots;
  logic                 found_free;
  logic [IDX_W-1:0]     load_idx;
  logic                 accept;
  logic                 hit_found;
  logic [15:0]          rom_full;

  always_comb begin
    valid_d       = valid_q;
    x_d           = x_q;
    y_d           = y_q;
    cd_d          = cd_q;
    found_free    = 1'b0;
    load_idx      = '0;
    hit_found     = 1'b0;
    rom_full      = '0;
    rom_address_d = '0;

    // A slot being cleared this cycle is not available to a new shot.
    free_slots = ~valid_q & ~hit_clear;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_slots[i]) begin
        found_free = 1'b1;
        load_idx   = IDX_W'(i);
      end
    end
    accept = fire && (cd_q == '0) && found_free;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_clear[i]) begin
        valid_d[i] = 1'b0;
      end else if (accept && (load_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
        x_d[i]     = fire_x;
        y_d[i]     = fire_y;
      end else if (frame_tick && valid_q[i]) begin
        if (({1'b0, y_q[i]} + 11'(SPEED)) >= 11'(SCREEN_H)) begin
          valid_d[i] = 1'b0;
        end else begin
          y_d[i] = y_q[i] + 10'(SPEED);
        end
      end
    end

    if (accept) begin
      cd_d = CD_W'(COOLDOWN);
    end else if (frame_tick && (cd_q != '0)) begin
      cd_d = cd_q - 1'b1;
    end

    // Lowest-index live bullet covering the scan pixel supplies the sprite index.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit_found && valid_q[i] &&
          ({1'b0, DrawX} >= {1'b0, x_q[i]}) &&
          ({1'b0, DrawX} <  ({1'b0, x_q[i]} + 11'(AMMO_W))) &&
          ({1'b0, DrawY} >= {1'b0, y_q[i]}) &&
          ({1'b0, DrawY} <  ({1'b0, y_q[i]} + 11'(AMMO_H)))) begin
        hit_found     = 1'b1;
        rom_full      = 16'(DrawY - y_q[i]) * 16'(AMMO_W) + 16'(DrawX - x_q[i]);
        rom_address_d = rom_full[7:0];
      end
    end

    ammo_on_d     = hit_found;
    fire_accept_d = accept;
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      valid_q       <= '0;
      cd_q          <= '0;
      fire_accept_q <= 1'b0;
      ammo_on_q     <= 1'b0;
      rom_address_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      cd_q          <= cd_d;
      fire_accept_q <= fire_accept_d;
      ammo_on_q     <= ammo_on_d;
      rom_address_q <= rom_address_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  assign fire_accept = fire_accept_q;
  assign active_mask = valid_q;
  assign ammo_on     = ammo_on_q;
  assign rom_address = rom_address_q;

endmodule

// File: tb/tb_enemy_ammo_controller.sv
// tb/tb_enemy_ammo_controller.sv - directed bench with a slot-level reference model
// Drives a COOLDOWN=30 and a COOLDOWN=0 instance with shared stimulus and checks both every cycle.
module tb_enemy_ammo_controller;

  logic       vga_clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       fire;
  logic [9:0] fire_x, fire_y;
  logic [3:0] hit_clear;
  logic [9:0] DrawX, DrawY;

  logic       fa0, fa1;
  logic [3:0] am0, am1;
  logic       on0, on1;
  logic [7:0] rom0, rom1;

  always #5 vga_clk = ~vga_clk;

  enemy_ammo_controller #(.COOLDOWN(30)) u_cd30 (
    .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
    .fire_x(fire_x), .fire_y(fire_y), .hit_clear(hit_clear),
    .DrawX(DrawX), .DrawY(DrawY),
    .fire_accept(fa0), .active_mask(am0), .ammo_on(on0), .rom_address(rom0)
  );

  enemy_ammo_controller #(.COOLDOWN(0)) u_cd0 (
    .vga_clk(vga_clk), .Reset(Reset), .frame_tick(frame_tick), .fire(fire),
    .fire_x(fire_x), .fire_y(fire_y), .hit_clear(hit_clear),
    .DrawX(DrawX), .DrawY(DrawY),
    .fire_accept(fa1), .active_mask(am1), .ammo_on(on1), .rom_address(rom1)
  );

  int errors = 0;
  int checks = 0;

  int mv  [2][4];
  int mx  [2][4];
  int my  [2][4];
  int mcd [2];
  int e_fa[2];
  int e_on[2];
  int e_rom[2];
  int cmax[2] = '{30, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int model_mask(input int k);
    int m;
    m = 0;
    for (int i = 0; i < 4; i++) m += mv[k][i] << i;
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        mv[k][i] = 0; mx[k][i] = 0; my[k][i] = 0;
      end
      mcd[k] = 0; e_fa[k] = 0; e_on[k] = 0; e_rom[k] = 0;
    end
  endtask

  // Next-state of each instance from the bullet rules, evaluated on the pre-edge inputs.
  task automatic model_step();
    int slot;
    int acc;
    int dx, dy;
    if (Reset) begin
      model_reset();
    end else begin
      dx = int'(DrawX);
      dy = int'(DrawY);
      for (int k = 0; k < 2; k++) begin
        e_on[k]  = 0;
        e_rom[k] = 0;
        for (int i = 0; i < 4; i++) begin
          if (e_on[k] == 0 && mv[k][i] == 1 &&
              dx >= mx[k][i] && dx < mx[k][i] + 10 &&
              dy >= my[k][i] && dy < my[k][i] + 20) begin
            e_on[k]  = 1;
            e_rom[k] = ((dy - my[k][i]) * 10 + (dx - mx[k][i])) % 256;
          end
        end
        slot = -1;
        for (int i = 0; i < 4; i++)
          if (slot < 0 && mv[k][i] == 0 && hit_clear[i] == 1'b0) slot = i;
        acc = (fire && mcd[k] == 0 && slot >= 0) ? 1 : 0;
        e_fa[k] = acc;
        for (int i = 0; i < 4; i++) begin
          if (hit_clear[i]) begin
            mv[k][i] = 0;
          end else if (acc == 1 && i == slot) begin
            mv[k][i] = 1;
            mx[k][i] = int'(fire_x);
            my[k][i] = int'(fire_y);
          end else if (frame_tick && mv[k][i] == 1) begin
            if (my[k][i] + 4 >= 480) mv[k][i] = 0;
            else my[k][i] = my[k][i] + 4;
          end
        end
        if (acc == 1) mcd[k] = cmax[k];
        else if (frame_tick && mcd[k] > 0) mcd[k] = mcd[k] - 1;
      end
    end
  endtask

  task automatic check_all();
    chk("cd30_fire_accept", int'(fa0), e_fa[0]);
    chk("cd30_active_mask", int'(am0), model_mask(0));
    chk("cd30_ammo_on", int'(on0), e_on[0]);
    chk("cd30_rom_address", int'(rom0), e_rom[0]);
    chk("cd0_fire_accept", int'(fa1), e_fa[1]);
    chk("cd0_active_mask", int'(am1), model_mask(1));
    chk("cd0_ammo_on", int'(on1), e_on[1]);
    chk("cd0_rom_address", int'(rom1), e_rom[1]);
  endtask

  task automatic tick();
    model_step();
    @(posedge vga_clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    fire = 1'b0; frame_tick = 1'b0; hit_clear = 4'b0;
  endtask

  task automatic shoot(input int x, input int y);
    fire = 1'b1; fire_x = 10'(x); fire_y = 10'(y);
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk({tag, "_mask0"}, int'(am0), 0);
    chk({tag, "_mask1"}, int'(am1), 0);
    chk({tag, "_on1"}, int'(on1), 0);
    chk({tag, "_rom1"}, int'(rom1), 0);
    chk({tag, "_fa0"}, int'(fa0), 0);
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    fire_x = '0; fire_y = '0; DrawX = '0; DrawY = '0;
    model_reset();
    #1;
    check_all();
    chk("reset_mask", int'(am0), 0);
    chk("reset_on", int'(on0), 0);
    tick();
    tick();
    Reset = 1'b0;

    shoot(100, 50);
    tick();
    chk("first_accept", int'(fa0), 1);
    chk("first_mask", int'(am0), 1);

    shoot(300, 100);
    DrawX = 10'd105; DrawY = 10'd60;
    tick();
    chk("cooldown_reject", int'(fa0), 0);
    chk("pixel_on", int'(on0), 1);
    chk("pixel_rom", int'(rom0), 105);
    chk("cd0_second_accept", int'(fa1), 1);

    idle();
    DrawX = 10'd110;
    tick();
    chk("pixel_right_edge", int'(on0), 0);

    frame_tick = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    frame_tick = 1'b0;
    DrawX = 10'd100; DrawY = 10'd61;
    tick();
    chk("moved_top_above", int'(on0), 0);
    DrawY = 10'd62;
    tick();
    chk("moved_top_on", int'(on0), 1);
    chk("moved_top_rom", int'(rom0), 0);

    frame_tick = 1'b1;
    for (int n = 0; n < 27; n++) tick();
    frame_tick = 1'b0;
    shoot(200, 472);
    tick();
    chk("after_cooldown_accept", int'(fa0), 1);
    chk("after_cooldown_mask", int'(am0), 3);

    idle();
    frame_tick = 1'b1;
    tick();
    chk("despawn_476_mask", int'(am0), 3);
    chk("accept_one_cycle", int'(fa0), 0);
    tick();
    chk("despawn_gone_mask", int'(am0), 1);
    idle();
    tick();

    async_reset_check("reset_mid");

    shoot(300, 100); tick();
    shoot(305, 105); tick();
    shoot(10, 10);   tick();
    shoot(20, 300);  tick();
    chk("full_mask", int'(am1), 15);
    shoot(0, 0); tick();
    chk("full_reject", int'(fa1), 0);
    hit_clear = 4'b0100;
    tick();
    chk("clear_fire_reject", int'(fa1), 0);
    chk("clear_mask", int'(am1), 11);
    hit_clear = 4'b0000;
    shoot(400, 400);
    tick();
    chk("refill_accept", int'(fa1), 1);
    chk("refill_mask", int'(am1), 15);

    idle();
    DrawX = 10'd306; DrawY = 10'd106;
    tick();
    chk("overlap_on", int'(on1), 1);
    chk("overlap_rom_slot0", int'(rom1), 66);

    DrawY = 10'd105;
    for (int x = 295; x <= 320; x++) begin
      DrawX = 10'(x);
      tick();
    end
    DrawY = 10'd119; DrawX = 10'd309; tick();
    DrawY = 10'd120; tick();
    DrawY = 10'd124; DrawX = 10'd314; tick();
    DrawY = 10'd125; tick();

    DrawX = 10'd306; DrawY = 10'd106;
    tick();
    async_reset_check("reset_live");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
